led_sweep_ctrl: RTL and testbench

//  Sequencer for the 8-LED sine-sweep display. Accepts commands over a valid/ready handshake
//  (loop, single sweep, stop) and a programmable step period. Steps a 4-bit phase through the
//  16-entry sine table, decodes it to a one-hot LED position and drives the registered LED bus.

---
 rtl/led_pkg.sv | 21 ++
 rtl/led_sine_decode.sv | 27 ++
 rtl/led_sweep_ctrl.sv | 108 ++++++++++
 tb/tb_led_sweep_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared command opcodes, FSM state encoding and sine table for the LED sweep sequencer.
package led_pkg;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_LOOP   = 2'b01;
    localparam logic [1:0] OP_SINGLE = 2'b10;
    localparam logic [1:0] OP_STOP   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOOP = 2'b01,
        ST_ONE  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [7:0] SINE_TAB [16] = '{
        8'h00, 8'h35, 8'h68, 8'h96, 8'hbe, 8'hdd, 8'hf3, 8'hfe,
        8'hfe, 8'hf3, 8'hdd, 8'hbe, 8'h96, 8'h68, 8'h35, 8'h00
    };

endpackage

// File: rtl/led_sine_decode.sv
// Maps a 4-bit phase through the sine table to a one-hot LED position.
// Latency: combinational.
// Backpressure: none.
module led_sine_decode
    import led_pkg::*;
(
    input  logic [3:0] phase,
    output logic [7:0] led
);

    logic [3:0] nib;
    logic [3:0] rev;

    assign nib = SINE_TAB[phase][7:4];
    assign rev = 4'd14 - nib;

    // Upper half of the nibble range folds back down so the spot bounces.
    always_comb begin
        led = 8'h01;
        if (!nib[3]) begin
            led = 8'h01 << nib[2:0];
        end else if (nib != 4'hf) begin
            led = 8'h01 << rev[2:0];
        end
    end

endmodule

// File: rtl/led_sweep_ctrl.sv
// Command-driven sine-sweep sequencer driving a registered one-hot 8-LED bus.
// Latency: accept -> phase 0 next clk; q follows phase by one clk.
// Backpressure: cmd_ready drops only for the single DONE cycle.
module led_sweep_ctrl
    import led_pkg::*;
#(
    parameter int PER_W      = 16,
    parameter int DEF_PERIOD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [PER_W-1:0] cmd_period,
    output logic             busy,
    output logic             done,
    output logic [3:0]       phase,
    output logic [7:0]       q
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             start;
    logic             stop;
    logic             tick;
    logic             last;
    logic [PER_W-1:0] period;
    logic [PER_W-1:0] step_cnt;
    logic [7:0]       led;

    assign busy      = (state == ST_LOOP) || (state == ST_ONE);
    assign done      = (state == ST_DONE);
    assign cmd_ready = (state != ST_DONE);

    assign accept = cmd_valid & cmd_ready;
    assign start  = accept & ((cmd_op == OP_LOOP) || (cmd_op == OP_SINGLE));
    assign stop   = accept & (cmd_op == OP_STOP) & busy;
    assign tick   = busy & (step_cnt == period - PER_W'(1));
    assign last   = (state == ST_ONE) && (phase == 4'd15);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A new LOOP/SINGLE outranks STOP-less ticks; STOP outranks the final tick.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (cmd_op == OP_LOOP) ? ST_LOOP : ST_ONE;
                end
            end
            ST_LOOP, ST_ONE: begin
                if (start) begin
                    state_nxt = (cmd_op == OP_LOOP) ? ST_LOOP : ST_ONE;
                end else if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (tick && last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period   <= PER_W'(DEF_PERIOD);
            phase    <= 4'd0;
            step_cnt <= '0;
            q        <= 8'h00;
        end else begin
            q <= busy ? led : 8'h00;
            if (start) begin
                period   <= (cmd_period == '0) ? PER_W'(1) : cmd_period;
                phase    <= 4'd0;
                step_cnt <= '0;
            end else if (!busy || stop) begin
                step_cnt <= '0;
            end else if (tick) begin
                step_cnt <= '0;
                if (!last) begin
                    phase <= phase + 4'd1;
                end
            end else begin
                step_cnt <= step_cnt + PER_W'(1);
            end
        end
    end

    led_sine_decode u_decode (
        .phase (phase),
        .led   (led)
    );

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Directed and randomized command sequences checked cycle by cycle against a sweep-time model.
module tb_led_sweep_ctrl;

    localparam logic [1:0] C_NOP    = 2'b00;
    localparam logic [1:0] C_LOOP   = 2'b01;
    localparam logic [1:0] C_SINGLE = 2'b10;
    localparam logic [1:0] C_STOP   = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_period;
    logic        busy;
    logic        done;
    logic [3:0]  phase;
    logic [7:0]  q;

    led_sweep_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_period (cmd_period),
        .busy       (busy),
        .done       (done),
        .phase      (phase),
        .q          (q)
    );

    always #5 clk = ~clk;

    logic [7:0] qtab [16] = '{
        8'h01, 8'h08, 8'h40, 8'h20, 8'h08, 8'h02, 8'h01, 8'h01,
        8'h01, 8'h01, 8'h02, 8'h08, 8'h20, 8'h40, 8'h08, 8'h01
    };

    int passed = 0;
    int total  = 0;

    // Model: mode 0 idle, 1 loop, 2 single, 3 done; m_t = clocks elapsed since phase 0.
    int m_mode = 0;
    int m_t    = 0;
    int m_p    = 16;
    int m_hold = 0;
    bit prev_busy  = 1'b0;
    int prev_phase = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    function automatic int exp_phase();
        case (m_mode)
            1:       return (m_t / m_p) % 16;
            2:       return m_t / m_p;
            3:       return 15;
            default: return m_hold;
        endcase
    endfunction

    function automatic bit exp_busy();
        return (m_mode == 1) || (m_mode == 2);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        chk("q", q, prev_busy ? qtab[prev_phase] : 8'h00);
        chk("phase", {4'b0, phase}, 8'(exp_phase()));
        chk("busy", {7'b0, busy}, {7'b0, exp_busy()});
        chk("done", {7'b0, done}, {7'b0, m_mode == 3});
        chk("cmd_ready", {7'b0, cmd_ready}, {7'b0, m_mode != 3});
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic cycle(input bit v, input logic [1:0] op, input logic [15:0] per);
        bit acc;
        bit cur_busy;
        int cur_phase;
        check_outputs();
        cmd_valid  = v;
        cmd_op     = op;
        cmd_period = per;
        acc        = v && (m_mode != 3);
        cur_busy   = exp_busy();
        cur_phase  = exp_phase();
        @(posedge clk);
        prev_busy  = cur_busy;
        prev_phase = cur_phase;
        if (acc && (op == C_LOOP || op == C_SINGLE)) begin
            m_mode = (op == C_LOOP) ? 1 : 2;
            m_t    = 0;
            m_p    = (per == 16'd0) ? 1 : int'(per);
        end else if (acc && op == C_STOP && cur_busy) begin
            m_hold = cur_phase;
            m_mode = 0;
        end else begin
            case (m_mode)
                1: m_t++;
                2: if (m_t == 16 * m_p - 1) m_mode = 3; else m_t++;
                3: begin m_mode = 0; m_hold = 15; end
                default: ;
            endcase
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, C_NOP, 16'd0);
    endtask

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_p = 16; m_hold = 0;
        prev_busy = 1'b0; prev_phase = 0;
    endtask

    task automatic mid_reset();
        cmd_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_q", q, 8'h00);
        chk("rst_phase", {4'b0, phase}, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_done", {7'b0, done}, 8'h00);
        chk("rst_ready", {7'b0, cmd_ready}, 8'h01);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        int acc_cyc;
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = C_NOP; cmd_period = 16'd0;
        #1;
        chk("init_q", q, 8'h00);
        chk("init_busy", {7'b0, busy}, 8'h00);
        chk("init_ready", {7'b0, cmd_ready}, 8'h01);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        idle(2);

        // SINGLE, period 2: full sweep, one done pulse 33 cycles after accept.
        done_cnt = 0;
        acc_cyc  = cyc;
        cycle(1'b1, C_SINGLE, 16'd2);
        idle(38);
        chk("single_done_count", 8'(done_cnt), 8'd1);
        chk("single_len", 8'(done_cyc - acc_cyc), 8'd33);

        // LOOP, period 0 behaves as period 1 and wraps 15 -> 0.
        done_cnt = 0;
        cycle(1'b1, C_LOOP, 16'd0);
        idle(40);
        chk("loop_no_done", 8'(done_cnt), 8'd0);

        // LOOP, period 4, STOP at phase 5.
        cycle(1'b1, C_LOOP, 16'd4);
        for (int i = 0; i < 200 && exp_phase() != 5; i++) cycle(1'b0, C_NOP, 16'd0);
        cycle(1'b1, C_STOP, 16'd0);
        idle(4);
        cycle(1'b1, C_STOP, 16'd0);
        idle(2);

        // SINGLE, period 3, STOP on the final tick cycle, then LOOP restart.
        done_cnt = 0;
        cycle(1'b1, C_SINGLE, 16'd3);
        for (int i = 0; i < 200 && !(m_mode == 2 && m_t == 47); i++) cycle(1'b0, C_NOP, 16'd0);
        cycle(1'b1, C_STOP, 16'd0);
        cycle(1'b1, C_LOOP, 16'd2);
        idle(10);
        chk("stop_final_no_done", 8'(done_cnt), 8'd0);

        // Restart while running, landing on a tick cycle.
        for (int i = 0; i < 50 && !(m_t % 2 == 1 && m_t > 6); i++) cycle(1'b0, C_NOP, 16'd0);
        cycle(1'b1, C_SINGLE, 16'd2);
        idle(6);

        // Command offered during DONE is held off one cycle.
        cycle(1'b1, C_SINGLE, 16'd1);
        for (int i = 0; i < 100 && m_mode != 3; i++) cycle(1'b0, C_NOP, 16'd0);
        cycle(1'b1, C_LOOP, 16'd1);
        cycle(1'b1, C_LOOP, 16'd1);
        idle(5);

        // Reset in the middle of a LOOP.
        cycle(1'b1, C_LOOP, 16'($urandom_range(1, 3)));
        idle($urandom_range(5, 40));
        mid_reset();
        idle(3);

        // Randomized command traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                mid_reset();
            end else begin
                cycle($urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
                      16'($urandom_range(0, 4)));
            end
        end
        idle(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
